timer_config_ctrl: RTL and testbench
====================================

# timer_config_ctrl

Front-end controller for the two-digit countdown timer. It turns pre-shaped single-cycle user button pulses into a BCD preset of 00–90 seconds, loads that preset into the timer with a one-cycle reconfigure strobe, drives the timer's `enable`, and watches `timeOutCTRL` to detect expiry. It sits between the button debouncers and the countdown timer, and is the writer side of the timer's `userDigit` / reconfigure / `enable` interface.

## Interface
Parameters:
- `MAX_TEN`, default 9: largest tens digit. When tens equals `MAX_TEN`, ones is forced to 0, so the ceiling is 90 s.

Ports:
- `clk` input, 1: system clock.
- `rst` input, 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `incTEN` input, 1: single-cycle pulse that increments the tens digit.
- `incONE` input, 1: single-cycle pulse that increments the ones digit.
- `startPress` input, 1: single-cycle pulse that loads the preset and starts the timer; in DONE it acknowledges expiry.
- `abortPress` input, 1: single-cycle pulse that stops the run and returns to SET.
- `timeOutCTRL` input, 1: timeout/disabled indication from the timer.
- `userDigitTEN` output, 4: preset tens digit, BCD.
- `userDigitONE` output, 4: preset ones digit, BCD.
- `timerReconfigTEN_ONE` output, 1: one-cycle load strobe to the timer.
- `enable` output, 1: timer run enable.
- `running` output, 1: high in ARM and RUN.
- `expired` output, 1: high in DONE.

## Operation
- States: SET, LOAD, ARM, RUN, DONE.
- All outputs are registered and are a Moore function of the state and the digit registers.
- **SET**
  - Per-cycle priority: `startPress` > `incTEN` > `incONE`. Only one action is taken per cycle.
  - `startPress` goes to LOAD.
  - `incTEN` sets tens = (tens==`MAX_TEN`) ? 0 : tens+1. If the new tens equals `MAX_TEN`, ones is cleared to 0 in the same cycle.
  - `incONE` sets ones = (ones==9) ? 0 : ones+1. It is ignored while tens equals `MAX_TEN`.
  - `abortPress` is ignored.
- **LOAD**
  - `timerReconfigTEN_ONE`=1 and `enable`=0.
  - Unconditionally goes to ARM. Inputs are ignored.
- **ARM**
  - `enable`=1.
  - `timeOutCTRL` is ignored for this settling cycle.
  - `abortPress` goes to SET; otherwise goes to RUN.
- **RUN**
  - `enable`=1.
  - `abortPress` goes to SET and takes priority over timeout.
  - Otherwise, `timeOutCTRL`=1 goes to DONE.
- **DONE**
  - `enable`=0 and `expired`=1.
  - `startPress` or `abortPress` goes to SET.
- Digits hold their values in every state except SET. They are never modified by the timer's count. A re-start reloads the same preset.
- Digits are always valid BCD. Values above 9, or a tens/ones combination above `MAX_TEN`0, are unreachable.

## Timing
- Reset values: state SET, `userDigitTEN`=0, `userDigitONE`=0, `timerReconfigTEN_ONE`=0, `enable`=0, `running`=0, `expired`=0.
- Reset mid-operation: outputs take their reset values on the cycle after `rst` is sampled high. The timer is disabled within 1 cycle.
- Digit update latency: the new value appears on the cycle after the `inc*` pulse.
- Start sequence, with `startPress` sampled in cycle n:
  - n+1: LOAD, strobe=1.
  - n+2: ARM, `enable`=1, strobe=0.
  - n+3: RUN.
  - The strobe is exactly 1 cycle wide and is never high while `enable`=1.
- Expiry: `timeOutCTRL` sampled high in RUN cycle k gives `enable`=0 and `expired`=1 in cycle k+1.
- Abort: `abortPress` sampled in ARM or RUN cycle k gives `enable`=0 and `running`=0 in cycle k+1.
- Simultaneous `abortPress` and `timeOutCTRL` in RUN: the result is SET and `expired` stays 0.
- Held inputs: an input high for m consecutive cycles counts as m events.

## Configuration
- Macro: `TIMER_CFG_ZERO_GUARD_EN`.
- Defined: `startPress` in SET with the preset at 00 is ignored. The state stays SET and no strobe is issued.
- Undefined: a preset of 00 is loaded and started. The timer reports timeout and the block enters DONE, normally at the first RUN cycle.

## Test plan
- Reset, then 3× `incTEN` and 5× `incONE` → digits 3/5. Then `startPress` → strobe high for exactly 1 cycle at n+1, `enable`=1 from n+2.
- 9× `incTEN` with ones=7 → digits 9/0. Then `incONE` → still 9/0. One more `incTEN` → 0/0.
- RUN with `timeOutCTRL` held low for 20 cycles, then high → `enable`=0 and `expired`=1 one cycle later. `startPress` → SET with the preset unchanged.
- `abortPress` and `timeOutCTRL` in the same RUN cycle → SET, `expired` never asserts. `rst` during RUN → all outputs at reset values the next cycle.
- `incTEN` and `incONE` in the same SET cycle → only tens increments. `timeOutCTRL`=1 during ARM → ignored, RUN entered.
- Preset 00 and `startPress`: with `TIMER_CFG_ZERO_GUARD_EN` → no strobe, stays SET. Without the macro → strobe, then DONE after the first RUN cycle.

Source files
------------

// File: rtl/timer_config_ctrl.sv
// rtl/timer_config_ctrl.sv - BCD preset entry and run control for the two-digit countdown timer
//
// Purpose: turns single-cycle button pulses into a 00..MAX_TEN0 BCD preset.
// It loads the preset into the timer with a one-cycle strobe, drives the
// timer enable, and watches timeOutCTRL to detect expiry.
//
// Ports:
//   clk                   system clock
//   rst                   synchronous active-high reset
//   incTEN / incONE       single-cycle pulses that increment the tens / ones digit
//   startPress            load preset and start; acknowledges expiry in DONE
//   abortPress            stop the run and return to SET
//   timeOutCTRL           timeout/disabled indication from the timer
//   userDigitTEN/ONE      preset digits, BCD
//   timerReconfigTEN_ONE  one-cycle load strobe to the timer
//   enable                timer run enable
//   running               high in ARM and RUN
//   expired               high in DONE
//
// Build option: TIMER_CFG_ZERO_GUARD_EN - when defined, startPress with a 00 preset is ignored.
module timer_config_ctrl #(
  parameter int MAX_TEN = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       incTEN,
  input  logic       incONE,
  input  logic       startPress,
  input  logic       abortPress,
  input  logic       timeOutCTRL,
  output logic [3:0] userDigitTEN,
  output logic [3:0] userDigitONE,
  output logic       timerReconfigTEN_ONE,
  output logic       enable,
  output logic       running,
  output logic       expired
);

  localparam logic [3:0] MaxTen = MAX_TEN[3:0];

  typedef enum logic [2:0] {
    S_SET,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       strobe_q, enable_q, running_q, expired_q;
  logic       start_ok;
  logic [3:0] tens_inc;

`ifdef TIMER_CFG_ZERO_GUARD_EN
  // A 00 preset would expire immediately, so the start request is dropped.
  assign start_ok = startPress && !((tens_q == 4'd0) && (ones_q == 4'd0));
`else
  assign start_ok = startPress;
`endif

  assign tens_inc = (tens_q == MaxTen) ? 4'd0 : tens_q + 4'd1;

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    unique case (state_q)
      S_SET: begin
        if (start_ok) begin
          state_d = S_LOAD;
        end else if (incTEN) begin
          tens_d = tens_inc;
          // Reaching the ceiling tens digit forces ones to 0 so the preset never exceeds MAX_TEN0.
          if (tens_inc == MaxTen) ones_d = 4'd0;
        end else if (incONE && (tens_q != MaxTen)) begin
          ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
        end
      end
      S_LOAD: state_d = S_ARM;
      // ARM is a settling cycle: timeOutCTRL may still reflect the pre-load timer state.
      S_ARM:  state_d = abortPress ? S_SET : S_RUN;
      S_RUN: begin
        if (abortPress)       state_d = S_SET;
        else if (timeOutCTRL) state_d = S_DONE;
      end
      S_DONE: if (startPress || abortPress) state_d = S_SET;
      default: state_d = S_SET;
    endcase
  end

  // Outputs are flopped from the next state, so they line up with state_q without a decode stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SET;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      strobe_q  <= 1'b0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      strobe_q  <= (state_d == S_LOAD);
      enable_q  <= (state_d == S_ARM) || (state_d == S_RUN);
      running_q <= (state_d == S_ARM) || (state_d == S_RUN);
      expired_q <= (state_d == S_DONE);
    end
  end

  assign userDigitTEN         = tens_q;
  assign userDigitONE         = ones_q;
  assign timerReconfigTEN_ONE = strobe_q;
  assign enable               = enable_q;
  assign running              = running_q;
  assign expired              = expired_q;

endmodule

// File: tb/tb_timer_config_ctrl.sv
// tb/tb_timer_config_ctrl.sv - directed self-checking bench for timer_config_ctrl
module tb_timer_config_ctrl;

  logic       clk = 1'b0;
  logic       rst, incTEN, incONE, startPress, abortPress, timeOutCTRL;
  logic [3:0] userDigitTEN, userDigitONE;
  logic       timerReconfigTEN_ONE, enable, running, expired;

  int checks = 0;
  int errors = 0;

  timer_config_ctrl #(.MAX_TEN(9)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .incTEN               (incTEN),
    .incONE               (incONE),
    .startPress           (startPress),
    .abortPress           (abortPress),
    .timeOutCTRL          (timeOutCTRL),
    .userDigitTEN         (userDigitTEN),
    .userDigitONE         (userDigitONE),
    .timerReconfigTEN_ONE (timerReconfigTEN_ONE),
    .enable               (enable),
    .running              (running),
    .expired              (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample point is 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ten(input int n);
    for (int i = 0; i < n; i++) begin
      incTEN = 1'b1; tick(); incTEN = 1'b0;
    end
  endtask

  task automatic pulse_one(input int n);
    for (int i = 0; i < n; i++) begin
      incONE = 1'b1; tick(); incONE = 1'b0;
    end
  endtask

  task automatic press_start();
    startPress = 1'b1; tick(); startPress = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] t, input logic [3:0] o,
                            input logic s, input logic e, input logic r, input logic x);
    check({tag, ".ten"},     userDigitTEN, t);
    check({tag, ".one"},     userDigitONE, o);
    check({tag, ".strobe"},  timerReconfigTEN_ONE, s);
    check({tag, ".enable"},  enable, e);
    check({tag, ".running"}, running, r);
    check({tag, ".expired"}, expired, x);
  endtask

  initial begin
    rst = 1'b0; incTEN = 1'b0; incONE = 1'b0;
    startPress = 1'b0; abortPress = 1'b0; timeOutCTRL = 1'b0;
    #2;
    do_reset();
    check_outs("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Preset 3/5 and start sequence
    pulse_ten(3);
    pulse_one(5);
    check_outs("preset35", 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    press_start();
    check_outs("load", 4'd3, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("arm", 4'd3, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_outs("run", 4'd3, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);

    // Timeout low for 20 RUN cycles, then expiry
    for (int i = 0; i < 20; i++) begin
      tick();
      check("run_hold.enable", enable, 1'b1);
      check("run_hold.expired", expired, 1'b0);
    end
    timeOutCTRL = 1'b1; tick(); timeOutCTRL = 1'b0;
    check_outs("done", 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("done_hold.expired", expired, 1'b1);
    press_start();
    check_outs("ack", 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort and timeout together in RUN: abort wins
    press_start(); tick(); tick();
    check("run2.enable", enable, 1'b1);
    abortPress = 1'b1; timeOutCTRL = 1'b1; tick();
    abortPress = 1'b0; timeOutCTRL = 1'b0;
    check_outs("abort_win", 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("abort_win2.expired", expired, 1'b0);

    // Reset during RUN
    press_start(); tick(); tick();
    check("run3.running", running, 1'b1);
    do_reset();
    check_outs("rst_run", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Tens ceiling: ones=7, 9x incTEN -> 9/0, incONE ignored, wrap to 0/0
    pulse_one(7);
    check("ones7.one", userDigitONE, 4'd7);
    pulse_ten(9);
    check("ceil.ten", userDigitTEN, 4'd9);
    check("ceil.one", userDigitONE, 4'd0);
    pulse_one(1);
    check("ceil_inc1.ten", userDigitTEN, 4'd9);
    check("ceil_inc1.one", userDigitONE, 4'd0);
    pulse_ten(1);
    check("wrap.ten", userDigitTEN, 4'd0);
    check("wrap.one", userDigitONE, 4'd0);

    // Ones wrap 9 -> 0
    pulse_one(10);
    check("one_wrap.one", userDigitONE, 4'd0);

    // incTEN and incONE in the same cycle: only tens moves
    incTEN = 1'b1; incONE = 1'b1; tick(); incTEN = 1'b0; incONE = 1'b0;
    check("both.ten", userDigitTEN, 4'd1);
    check("both.one", userDigitONE, 4'd0);

    // Held incONE for 3 cycles counts as 3 events
    incONE = 1'b1; tick(); tick(); tick(); incONE = 1'b0;
    check("held.one", userDigitONE, 4'd3);

    // abortPress ignored in SET
    abortPress = 1'b1; tick(); abortPress = 1'b0;
    check_outs("abort_set", 4'd1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // timeOutCTRL during ARM is ignored
    press_start();
    check("arm_to.load_strobe", timerReconfigTEN_ONE, 1'b1);
    tick();
    check("arm_to.arm_enable", enable, 1'b1);
    timeOutCTRL = 1'b1; tick();
    check("arm_to.run_enable", enable, 1'b1);
    check("arm_to.run_expired", expired, 1'b0);
    tick(); timeOutCTRL = 1'b0;
    check("arm_to.done", expired, 1'b1);
    abortPress = 1'b1; tick(); abortPress = 1'b0;
    check("arm_to.abort_done", expired, 1'b0);

    // Abort from ARM
    press_start(); tick();
    abortPress = 1'b1; tick(); abortPress = 1'b0;
    check_outs("abort_arm", 4'd1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero preset
    do_reset();
    press_start();
`ifdef TIMER_CFG_ZERO_GUARD_EN
    check_outs("zero_guard", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("zero_guard2.strobe", timerReconfigTEN_ONE, 1'b0);
    check("zero_guard2.running", running, 1'b0);
`else
    check_outs("zero_load", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("zero_arm.enable", enable, 1'b1);
    timeOutCTRL = 1'b1; tick();
    check("zero_run.enable", enable, 1'b1);
    tick(); timeOutCTRL = 1'b0;
    check_outs("zero_done", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
